// File: rtl/servgrid_pkg.sv
// Shared types and constants for the servgrid host bridge.
package servgrid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CORE_WAIT,
    RESP
  } state_e;

  // Host address bit that steers an access to the bridge's own registers.
  localparam int LOCAL_SEL_BIT = 20;

  // Local register byte offsets (decoded on adr[7:2]).
  localparam logic [7:0] REG_CORE_RUN = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;

  // STATUS field positions.
  localparam int STATUS_TO_BIT  = 0;
  localparam int STATUS_IDX_LSB = 8;
  localparam int STATUS_IDX_W   = 4;

endpackage

// File: rtl/servgrid_bridge_regs.sv
// Local register window: CORE_RUN gates the cores, STATUS records the last timeout.
module servgrid_bridge_regs
  import servgrid_pkg::*;
#(
  parameter int                NCORES  = 16,
  parameter logic [NCORES-1:0] RUN_RST = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [5:0]        word_i,
  input  logic [31:0]       wdata_i,
  input  logic              to_set_i,
  input  logic [3:0]        to_idx_i,
  output logic [NCORES-1:0] core_run_o,
  output logic [31:0]       rdata_o
);

  localparam logic [5:0] RUN_WORD    = REG_CORE_RUN[7:2];
  localparam logic [5:0] STATUS_WORD = REG_STATUS[7:2];

  logic [NCORES-1:0]       run_q;
  logic                    to_q;
  logic [STATUS_IDX_W-1:0] idx_q;

  // Only bit 0 and the low NCORES bits of write data matter; fold the rest away.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // Register storage; a timeout capture takes priority over a W1C of TO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= RUN_RST;
      to_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      if (wr_en_i && (word_i == RUN_WORD)) begin
        run_q <= wdata_i[NCORES-1:0];
      end
      if (to_set_i) begin
        to_q  <= 1'b1;
        idx_q <= to_idx_i;
      end else if (wr_en_i && (word_i == STATUS_WORD) && wdata_i[STATUS_TO_BIT]) begin
        to_q <= 1'b0;
      end
    end
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rdata_o = '0;
    if (word_i == RUN_WORD) begin
      rdata_o[NCORES-1:0] = run_q;
    end else if (word_i == STATUS_WORD) begin
      rdata_o[STATUS_TO_BIT] = to_q;
      rdata_o[STATUS_IDX_LSB +: STATUS_IDX_W] = idx_q;
    end
  end

  assign core_run_o = run_q;

endmodule

// File: rtl/servgrid_host_bridge.sv
// Shares one host Wishbone port across the grid's cores, one transaction at a time.
module servgrid_host_bridge
  import servgrid_pkg::*;
#(
  parameter int                NCORES  = 16,
  parameter int                SEL_LSB = 16,
  parameter int                TIMEOUT = 255,
  parameter logic [NCORES-1:0] RUN_RST = '1
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [31:0]          i_wb_host_adr,
  input  logic [31:0]          i_wb_host_dat,
  input  logic [3:0]           i_wb_host_sel,
  input  logic                 i_wb_host_we,
  input  logic                 i_wb_host_stb,
  output logic [31:0]          o_wb_host_rdt,
  output logic                 o_wb_host_ack,
  output logic                 o_wb_host_err,
  output logic [31:0]          o_wb_core_adr,
  output logic [31:0]          o_wb_core_dat,
  output logic [3:0]           o_wb_core_sel,
  output logic                 o_wb_core_we,
  output logic [NCORES-1:0]    o_wb_core_stb,
  input  logic [32*NCORES-1:0] i_wb_core_rdt,
  input  logic [NCORES-1:0]    i_wb_core_ack,
  output logic [NCORES-1:0]    o_core_rst_n
);

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e            state_q;
  logic [31:0]       adr_q, dat_q, rdt_q;
  logic [3:0]        sel_q, idx_q;
  logic              we_q, ack_q, err_q;
  logic [NCORES-1:0] stb_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        host_idx;
  logic              host_local, core_ok;
  logic [15:0]       run16, ack16, host_onehot;
  logic [32*16-1:0]  rdt16;
  logic [31:0]       core_rdt;
  logic              core_ack, to_hit;
  logic [NCORES-1:0] core_run;
  logic [31:0]       reg_rdata;
  logic              reg_wr;

  // Padding per-core vectors to 16 keeps every 4-bit index in range.
  assign run16       = 16'(core_run);
  assign ack16       = 16'(i_wb_core_ack);
  assign rdt16       = (32*16)'(i_wb_core_rdt);
  assign host_idx    = i_wb_host_adr[SEL_LSB +: 4];
  assign host_local  = i_wb_host_adr[LOCAL_SEL_BIT];
  assign host_onehot = 16'b1 << host_idx;
  assign core_ok     = ({1'b0, host_idx} < 5'(NCORES)) && run16[host_idx];
  assign core_ack    = ack16[idx_q];
  assign core_rdt    = rdt16[{idx_q, 5'b0} +: 32];

  // Saturating wait counter; a timeout fires on the cycle it would reach TIMEOUT.
  assign cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign to_hit = (state_q == CORE_WAIT) && !core_ack && (cnt_d == CNT_MAX);
  assign reg_wr = (state_q == IDLE) && i_wb_host_stb && host_local && i_wb_host_we;

  servgrid_bridge_regs #(
    .NCORES  (NCORES),
    .RUN_RST (RUN_RST)
  ) u_regs (
    .clk        (wb_clk),
    .rst_n      (wb_rst_n),
    .wr_en_i    (reg_wr),
    .word_i     (i_wb_host_adr[7:2]),
    .wdata_i    (i_wb_host_dat),
    .to_set_i   (to_hit),
    .to_idx_i   (idx_q),
    .core_run_o (core_run),
    .rdata_o    (reg_rdata)
  );

  // Transaction sequencer with registered host and core-side outputs.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (i_wb_host_stb) begin
            adr_q <= i_wb_host_adr;
            dat_q <= i_wb_host_dat;
            sel_q <= i_wb_host_sel;
            we_q  <= i_wb_host_we;
            idx_q <= host_idx;
            if (host_local) begin
              ack_q   <= 1'b1;
              rdt_q   <= reg_rdata;
              state_q <= RESP;
            end else if (!core_ok) begin
              err_q   <= 1'b1;
              rdt_q   <= '0;
              state_q <= RESP;
            end else begin
              stb_q   <= host_onehot[NCORES-1:0];
              cnt_q   <= '0;
              state_q <= CORE_WAIT;
            end
          end
        end
        CORE_WAIT: begin
          if (core_ack) begin
            stb_q   <= '0;
            ack_q   <= 1'b1;
            rdt_q   <= core_rdt;
            state_q <= RESP;
          end else if (to_hit) begin
            stb_q   <= '0;
            err_q   <= 1'b1;
            rdt_q   <= '0;
            cnt_q   <= cnt_d;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_host_rdt = rdt_q;
  assign o_wb_host_ack = ack_q;
  assign o_wb_host_err = err_q;
  assign o_wb_core_adr = adr_q;
  assign o_wb_core_dat = dat_q;
  assign o_wb_core_sel = sel_q;
  assign o_wb_core_we  = we_q;
  assign o_wb_core_stb = stb_q;
  assign o_core_rst_n  = core_run & {NCORES{wb_rst_n}};

endmodule

// File: tb/tb_servgrid_host_bridge.sv
// Directed bench for servgrid_host_bridge with a transaction-level model and per-cycle compare.
module tb_servgrid_host_bridge;

  localparam int NC  = 16;
  localparam int NC12 = 12;
  localparam int TO  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstN;
  logic [31:0]       hAdr, hDat;
  logic [3:0]        hSel;
  logic              hWe, hStb, hStb12;

  logic [31:0]       hRdt, coreAdr, coreDat;
  logic              hAck, hErr, coreWe;
  logic [3:0]        coreSel;
  logic [NC-1:0]     coreStb, coreAck, coreRstN;
  logic [32*NC-1:0]  coreRdt;

  logic [31:0]       hRdt12, coreAdr12, coreDat12;
  logic              hAck12, hErr12, coreWe12;
  logic [3:0]        coreSel12;
  logic [NC12-1:0]   coreStb12, coreRstN12;
  logic [NC12-1:0]   coreAck12 = '0;
  logic [32*NC12-1:0] coreRdt12 = '0;

  servgrid_host_bridge #(.NCORES(NC), .SEL_LSB(16), .TIMEOUT(TO)) dut (
    .wb_clk(clk), .wb_rst_n(rstN),
    .i_wb_host_adr(hAdr), .i_wb_host_dat(hDat), .i_wb_host_sel(hSel),
    .i_wb_host_we(hWe), .i_wb_host_stb(hStb),
    .o_wb_host_rdt(hRdt), .o_wb_host_ack(hAck), .o_wb_host_err(hErr),
    .o_wb_core_adr(coreAdr), .o_wb_core_dat(coreDat), .o_wb_core_sel(coreSel),
    .o_wb_core_we(coreWe), .o_wb_core_stb(coreStb),
    .i_wb_core_rdt(coreRdt), .i_wb_core_ack(coreAck), .o_core_rst_n(coreRstN)
  );

  servgrid_host_bridge #(.NCORES(NC12), .SEL_LSB(16), .TIMEOUT(TO)) dut12 (
    .wb_clk(clk), .wb_rst_n(rstN),
    .i_wb_host_adr(hAdr), .i_wb_host_dat(hDat), .i_wb_host_sel(hSel),
    .i_wb_host_we(hWe), .i_wb_host_stb(hStb12),
    .o_wb_host_rdt(hRdt12), .o_wb_host_ack(hAck12), .o_wb_host_err(hErr12),
    .o_wb_core_adr(coreAdr12), .o_wb_core_dat(coreDat12), .o_wb_core_sel(coreSel12),
    .o_wb_core_we(coreWe12), .o_wb_core_stb(coreStb12),
    .i_wb_core_rdt(coreRdt12), .i_wb_core_ack(coreAck12), .o_core_rst_n(coreRstN12)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural model of the register window.
  logic [NC-1:0] mdlRun;
  logic          mdlTo;
  logic [3:0]    mdlIdx;

  // Expected outputs for the current cycle.
  logic          checkEn = 1'b0;
  logic          expAck, expErr, expChkRdt, expWe;
  logic [31:0]   expRdt, expAdr, expDat;
  logic [NC-1:0] expStb;

  // Values captured from the last response for hand-computed literal checks.
  logic [31:0]   lastRdt;
  logic          lastAck, lastErr;
  int            stbCycles;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdlRead(input logic [5:0] word);
    logic [31:0] r;
    r = '0;
    if (word == 6'd0) r[NC-1:0] = mdlRun;
    else if (word == 6'd1) begin
      r[0]    = mdlTo;
      r[11:8] = mdlIdx;
    end
    return r;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
    expAck    = 1'b0;
    expErr    = 1'b0;
    expChkRdt = 1'b0;
    expStb    = '0;
  endtask

  // Every cycle after reset: host response, strobes, broadcast fields and core resets.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("host_ack", 32'(hAck), 32'(expAck));
      checkOutput("host_err", 32'(hErr), 32'(expErr));
      checkOutput("core_stb", 32'(coreStb), 32'(expStb));
      checkOutput("core_rst_n", 32'(coreRstN), 32'(rstN ? mdlRun : '0));
      if (expChkRdt) checkOutput("host_rdt", hRdt, expRdt);
      if (expStb != '0) begin
        checkOutput("core_adr", coreAdr, expAdr);
        checkOutput("core_dat", coreDat, expDat);
        checkOutput("core_we", 32'(coreWe), 32'(expWe));
        checkOutput("core_sel", 32'(coreSel), 32'hF);
      end
    end
  end

  task automatic captureResponse();
    @(negedge clk);
    lastRdt = hRdt;
    lastAck = hAck;
    lastErr = hErr;
  endtask

  // One host transaction; ackDelay is the stb cycle (0-based) the core acks in, -1 never.
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                               input int ackDelay, input logic [31:0] rdt,
                               input int spurCore, input logic [31:0] spurRdt);
    logic [3:0]  idx;
    logic [31:0] rd;
    int          cnt;
    bit          ackedPrev, done;
    idx = adr[19:16];
    hAdr = adr; hDat = dat; hWe = we; hSel = 4'hF; hStb = 1'b1;
    cnt = 0; ackedPrev = 0; done = 0;
    if (adr[20]) begin
      rd = mdlRead(adr[7:2]);
      nextCycle();
      if (we && adr[7:2] == 6'd0) mdlRun = dat[NC-1:0];
      if (we && adr[7:2] == 6'd1 && dat[0]) mdlTo = 1'b0;
      expAck = 1'b1; expRdt = rd; expChkRdt = 1'b1;
    end else if (int'(idx) >= NC || !mdlRun[idx]) begin
      nextCycle();
      expErr = 1'b1; expRdt = '0; expChkRdt = 1'b1;
    end else begin
      expAdr = adr; expDat = dat; expWe = we;
      coreRdt[32*idx +: 32] = rdt;
      if (spurCore >= 0) coreRdt[32*spurCore +: 32] = spurRdt;
      while (!done) begin
        nextCycle();
        if (ackedPrev) begin
          coreAck = '0;
          expAck = 1'b1; expRdt = rdt; expChkRdt = 1'b1;
          done = 1;
        end else if (cnt == TO) begin
          coreAck = '0;
          expErr = 1'b1;
          mdlTo = 1'b1; mdlIdx = idx;
          done = 1;
        end else begin
          expStb = NC'(1) << idx;
          coreAck = '0;
          if (spurCore >= 0) coreAck[spurCore] = 1'b1;
          if (cnt == ackDelay) coreAck[idx] = 1'b1;
          ackedPrev = (cnt == ackDelay);
          cnt++;
        end
      end
    end
    stbCycles = cnt;
    captureResponse();
    nextCycle();
    hStb = 1'b0;
    coreAck = '0;
    coreRdt = '0;
  endtask

  // Starts a core access that never acks, then resets the bridge mid-wait.
  task automatic applyAbort(input logic [3:0] idx, input int waitCycles);
    hAdr = {12'h000, idx, 16'h0000}; hDat = 32'h0; hWe = 1'b0; hStb = 1'b1;
    expAdr = hAdr; expDat = 32'h0; expWe = 1'b0;
    for (int i = 0; i < waitCycles; i++) begin
      nextCycle();
      expStb = NC'(1) << idx;
    end
    nextCycle();
    expStb = NC'(1) << idx;
    rstN = 1'b0;
    hStb = 1'b0;
    nextCycle();
    rstN = 1'b1;
    mdlRun = '1; mdlTo = 1'b0; mdlIdx = '0;
    nextCycle();
  endtask

  initial begin
    rstN = 1'b0; hAdr = '0; hDat = '0; hSel = 4'hF; hWe = 1'b0; hStb = 1'b0; hStb12 = 1'b0;
    coreAck = '0; coreRdt = '0;
    mdlRun = '1; mdlTo = 1'b0; mdlIdx = '0;
    expAck = 0; expErr = 0; expChkRdt = 0; expStb = '0;
    expAdr = '0; expDat = '0; expWe = 0;
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b1;
    nextCycle();
    rstN = 1'b1;
    nextCycle();

    $display("[TB] local read of CORE_RUN after reset");
    applyStimulus(32'h0010_0000, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("reset_core_run_lit", lastRdt, 32'h0000_FFFF);
    checkOutput("reset_core_run_ack", 32'(lastAck), 32'h1);

    $display("[TB] write to core 5");
    applyStimulus(32'h0005_0040, 32'h1234_5678, 1'b1, 1, 32'h0, -1, 32'h0);
    checkOutput("core5_stb_cycles", 32'(stbCycles), 32'd2);
    checkOutput("core5_err", 32'(lastErr), 32'h0);

    $display("[TB] read core 3 with spurious core 7 ack");
    applyStimulus(32'h0003_0000, 32'h0, 1'b0, 4, 32'hCAFE_F00D, 7, 32'hDEAD_BEEF);
    checkOutput("core3_rdt_lit", lastRdt, 32'hCAFE_F00D);

    $display("[TB] core 9 timeout");
    applyStimulus(32'h0009_0000, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("timeout_stb_cycles", 32'(stbCycles), 32'd255);
    checkOutput("timeout_err", 32'(lastErr), 32'h1);
    applyStimulus(32'h0010_0004, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("status_after_to_lit", lastRdt, 32'h0000_0901);
    applyStimulus(32'h0010_0004, 32'h1, 1'b1, -1, 32'h0, -1, 32'h0);
    applyStimulus(32'h0010_0004, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("status_after_w1c_lit", lastRdt, 32'h0000_0900);

    $display("[TB] gate core 2 off and access it");
    applyStimulus(32'h0010_0000, 32'h0000_FFFB, 1'b1, -1, 32'h0, -1, 32'h0);
    applyStimulus(32'h0002_0000, 32'h0, 1'b0, 0, 32'h1111_2222, -1, 32'h0);
    checkOutput("gated_core_err", 32'(lastErr), 32'h1);
    checkOutput("gated_core_rst_n_lit", 32'(coreRstN), 32'h0000_FFFB);

    $display("[TB] unmapped local offset");
    applyStimulus(32'h0010_0008, 32'hFFFF_FFFF, 1'b1, -1, 32'h0, -1, 32'h0);
    applyStimulus(32'h0010_0008, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("unmapped_rdt_lit", lastRdt, 32'h0);

    $display("[TB] reset during core wait");
    applyAbort(4'd9, 3);
    applyStimulus(32'h0010_0000, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("core_run_after_abort_lit", lastRdt, 32'h0000_FFFF);
    applyStimulus(32'h0010_0004, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("status_after_abort_lit", lastRdt, 32'h0);

    $display("[TB] CORE_RUN upper bits and ack on core 15");
    applyStimulus(32'h0010_0000, 32'hFFFF_FFFF, 1'b1, -1, 32'h0, -1, 32'h0);
    applyStimulus(32'h0010_0000, 32'h0, 1'b0, -1, 32'h0, -1, 32'h0);
    checkOutput("core_run_upper_lit", lastRdt, 32'h0000_FFFF);
    applyStimulus(32'h000F_0010, 32'h0, 1'b0, 0, 32'h5A5A_A5A5, -1, 32'h0);
    checkOutput("core15_rdt_lit", lastRdt, 32'h5A5A_A5A5);

    $display("[TB] NCORES=12 instance");
    hAdr = 32'h000D_0000; hWe = 1'b0; hStb12 = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("n12_idx13_err", 32'(hErr12), 32'h1);
    checkOutput("n12_idx13_ack", 32'(hAck12), 32'h0);
    checkOutput("n12_idx13_stb", 32'(coreStb12), 32'h0);
    nextCycle();
    hStb12 = 1'b0;
    nextCycle();
    hAdr = 32'h0010_0000; hStb12 = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("n12_core_run_ack", 32'(hAck12), 32'h1);
    checkOutput("n12_core_run_rdt", hRdt12, 32'h0000_0FFF);
    checkOutput("n12_core_rst_n", 32'(coreRstN12), 32'h0000_0FFF);
    nextCycle();
    hStb12 = 1'b0;
    nextCycle();

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
